// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: request sources and pipeline handshake on one side,
// controller outputs on the other. master = sources/pipeline, slave = int_ctrl.
interface int_ctrl_if;
    logic        external_int;
    logic        ext_int_ack;
    logic        timer_int;
    logic        sw_int;
    logic        gie;
    logic [2:0]  int_en;
    logic        int_taken;
    logic        mret;
    logic        int_req;
    logic [31:0] int_cause;
    logic        in_handler;
    logic        ack_err;

    modport master (
        output external_int, timer_int, sw_int, gie, int_en, int_taken, mret,
        input  ext_int_ack, int_req, int_cause, in_handler, ack_err
    );

    modport slave (
        input  external_int, timer_int, sw_int, gie, int_en, int_taken, mret,
        output ext_int_ack, int_req, int_cause, in_handler, ack_err
    );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: CPU-side interrupt receiver for external/software/timer sources.
// Latches and masks requests, raises int_req with a frozen cause, completes the
// external request/ack handshake after the trap is taken, and blocks new
// requests until mret.
// Optional feature: define INT_SYNC_EN to pass external_int through a 2-flop
// synchronizer (adds 2 cycles of request latency).
module int_ctrl #(
    parameter int unsigned CAUSE_EXT     = 11,
    parameter int unsigned CAUSE_SW      = 3,
    parameter int unsigned CAUSE_TIMER   = 7,
    parameter int unsigned DRAIN_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    int_ctrl_if.slave  bus
);
    localparam int unsigned CAUSE_W = 32;
    localparam int unsigned CNT_W   = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ACK     = 3'd2,
        S_DRAIN   = 3'd3,
        S_HANDLER = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 sw_pend_q, sw_pend_d;
    logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [CAUSE_W-1:0]   int_cause_q, int_cause_d;
    logic                 int_req_q, int_req_d;
    logic                 ack_q, ack_d;
    logic                 in_handler_q, in_handler_d;
    logic                 ack_err_q, ack_err_d;

    logic                 ext_lvl;
    logic [2:0]           pend;
    logic [CAUSE_W-1:0]   win_cause;
    logic                 latched_pend;
    logic                 sw_clr;

`ifdef INT_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer on the asynchronous external request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.external_int};
        end
    end

    assign ext_lvl = sync_q[1];
`else
    assign ext_lvl = bus.external_int;
`endif

    assign pend = {ext_lvl & bus.int_en[2], sw_pend_q & bus.int_en[1], bus.timer_int & bus.int_en[0]};

    // Fixed priority pick: ext > sw > timer
    always_comb begin
        win_cause = '0;
        if (pend[2]) begin
            win_cause = CAUSE_W'(CAUSE_EXT);
        end else if (pend[1]) begin
            win_cause = CAUSE_W'(CAUSE_SW);
        end else if (pend[0]) begin
            win_cause = CAUSE_W'(CAUSE_TIMER);
        end
    end

    // Is the source behind the latched cause still requesting
    always_comb begin
        latched_pend = 1'b0;
        if (int_cause_q == CAUSE_W'(CAUSE_EXT)) begin
            latched_pend = pend[2];
        end else if (int_cause_q == CAUSE_W'(CAUSE_SW)) begin
            latched_pend = pend[1];
        end else if (int_cause_q == CAUSE_W'(CAUSE_TIMER)) begin
            latched_pend = pend[0];
        end
    end

    // Software pending bit: cleared when its trap is taken, a new pulse wins
    assign sw_clr = (state_q == S_REQ) && bus.int_taken && (int_cause_q == CAUSE_W'(CAUSE_SW));

    always_comb begin
        sw_pend_d = sw_pend_q;
        if (sw_clr) begin
            sw_pend_d = 1'b0;
        end
        if (bus.sw_int) begin
            sw_pend_d = 1'b1;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        int_cause_d = int_cause_q;
        drain_cnt_d = drain_cnt_q;
        ack_err_d   = ack_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.gie && (pend != 3'b000)) begin
                    state_d     = S_REQ;
                    int_cause_d = win_cause;
                end
            end
            S_REQ: begin
                if (bus.int_taken) begin
                    // Never ack a source whose line is already low
                    if ((int_cause_q == CAUSE_W'(CAUSE_EXT)) && bus.external_int) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_HANDLER;
                    end
                end else if (!bus.gie || !latched_pend) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                drain_cnt_d = '0;
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                if (!ext_lvl) begin
                    state_d = S_HANDLER;
                end else if (drain_cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    ack_err_d = 1'b1;
                    state_d   = S_HANDLER;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            S_HANDLER: begin
                if (bus.mret) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // int_req shows one cycle after entering REQ and drops as REQ is left
        int_req_d    = (state_q == S_REQ) && (state_d == S_REQ);
        ack_d        = (state_d == S_ACK);
        in_handler_d = (state_d == S_HANDLER);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sw_pend_q    <= 1'b0;
            drain_cnt_q  <= '0;
            int_cause_q  <= '0;
            int_req_q    <= 1'b0;
            ack_q        <= 1'b0;
            in_handler_q <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_pend_q    <= sw_pend_d;
            drain_cnt_q  <= drain_cnt_d;
            int_cause_q  <= int_cause_d;
            int_req_q    <= int_req_d;
            ack_q        <= ack_d;
            in_handler_q <= in_handler_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign bus.int_req     = int_req_q;
    assign bus.int_cause   = int_cause_q;
    assign bus.ext_int_ack = ack_q;
    assign bus.in_handler  = in_handler_q;
    assign bus.ack_err     = ack_err_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios plus randomized source/enable
// mixes checked against a priority/latency model of the controller.
module tb_int_ctrl;
    localparam logic [31:0] C_EXT = 32'd11;
    localparam logic [31:0] C_SW  = 32'd3;
    localparam logic [31:0] C_TMR = 32'd7;
    localparam int          TMO   = 8;
`ifdef INT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int DRAIN_LAT = (1 + SYNC > 2) ? 1 + SYNC : 2;

    logic clk = 1'b0;
    logic reset;

    int_ctrl_if bus();

    int_ctrl #(
        .CAUSE_EXT(11), .CAUSE_SW(3), .CAUSE_TIMER(7), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        m_swpend = 1'b0;
    logic        m_ackerr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; sw_int is only ever a single-cycle pulse
    task automatic tick();
        @(posedge clk);
        #1;
        bus.sw_int = 1'b0;
    endtask

    function automatic logic [31:0] pick(input logic e, input logic s, input logic t);
        if (e) return C_EXT;
        if (s) return C_SW;
        if (t) return C_TMR;
        return 32'd0;
    endfunction

    function automatic logic [31:0] pending_now();
        if (!bus.gie) return 32'd0;
        return pick(bus.external_int & bus.int_en[2], m_swpend & bus.int_en[1],
                    bus.timer_int & bus.int_en[0]);
    endfunction

    task automatic wait_req(input string tag, input int exp_lat, input logic [31:0] exp_cause);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.int_req !== 1'b1 && n < 12);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_cause"}, bus.int_cause, exp_cause);
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen = seen | bus.int_req | bus.ext_int_ack;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic zero_chk(input string tag);
        check({tag, "_req"}, 32'(bus.int_req), 32'd0);
        check({tag, "_ack"}, 32'(bus.ext_int_ack), 32'd0);
        check({tag, "_hdl"}, 32'(bus.in_handler), 32'd0);
        check({tag, "_err"}, 32'(bus.ack_err), 32'd0);
        check({tag, "_cause"}, bus.int_cause, 32'd0);
    endtask

    // Take the trap, finish the ext handshake if any, sit in the handler, mret
    task automatic serve(input logic [31:0] cause, input bit timeout);
        int n;
        int acks;
        bus.int_taken = 1'b1;
        tick();
        bus.int_taken = 1'b0;
        check("taken_req_drop", 32'(bus.int_req), 32'd0);
        check("ack_pulse", 32'(bus.ext_int_ack), 32'(cause == C_EXT));
        if (cause == C_EXT) begin
            if (!timeout) bus.external_int = 1'b0;
            n = 0;
            acks = 0;
            do begin
                tick();
                n++;
                if (bus.ext_int_ack) acks++;
            end while (!bus.in_handler && n < 20);
            check("drain_len", 32'(n), 32'(timeout ? TMO + 1 : DRAIN_LAT));
            check("single_ack", 32'(acks), 32'd0);
            if (timeout) m_ackerr = 1'b1;
            bus.external_int = 1'b0;
        end else begin
            check("in_handler", 32'(bus.in_handler), 32'd1);
            if (cause == C_SW) m_swpend = 1'b0;
            if (cause == C_TMR) bus.timer_int = 1'b0;
        end
        quiet("handler_quiet", 3);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("handler_exit", 32'(bus.in_handler), 32'd0);
        check("ack_err", 32'(bus.ack_err), 32'(m_ackerr));
        check("cause_kept", bus.int_cause, cause);
    endtask

    task automatic serve_chain(input logic [31:0] first);
        logic [31:0] c;
        c = first;
        for (int k = 0; k < 4 && c != 32'd0; k++) begin
            serve(c, 1'b0);
            c = pending_now();
            if (c != 32'd0) wait_req("rereq", 2, c);
        end
    endtask

    task automatic idle();
        bus.external_int = 1'b0;
        bus.timer_int    = 1'b0;
        repeat (4) tick();
    endtask

    // Apply a source mix; the model finds the first edge any enabled source is
    // visible and picks the highest priority among those visible then
    task automatic run_case(input logic e, input logic s, input logic t, input logic g,
                            input logic [2:0] en, input bit wd);
        logic [31:0] c;
        int lat;
        bus.int_en = en;
        bus.gie = g;
        bus.external_int = e;
        bus.timer_int = t;
        bus.sw_int = s;
        c = 32'd0;
        lat = 0;
        if (g) begin
            for (int ed = 1; ed <= 3; ed++) begin
                if (c == 32'd0) begin
                    c = pick(e & en[2] & (ed >= 1 + SYNC),
                             en[1] & (m_swpend | (s & (ed >= 2))),
                             t & en[0]);
                    lat = ed + 1;
                end
            end
        end
        m_swpend = m_swpend | s;
        if (c == 32'd0) begin
            quiet("no_req", 6);
        end else begin
            wait_req("req", lat, c);
            tick();
            check("req_hold", 32'(bus.int_req), 32'd1);
            check("cause_frozen", bus.int_cause, c);
            if (wd) begin
                bus.gie = 1'b0;
                tick();
                check("withdraw", 32'(bus.int_req), 32'd0);
                quiet("withdrawn", 3);
                bus.gie = 1'b1;
                c = pending_now();
                wait_req("req_gie", 2, c);
            end
            serve_chain(c);
        end
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.external_int = 1'b0;
        bus.timer_int = 1'b0;
        bus.sw_int = 1'b0;
        bus.gie = 1'b0;
        bus.int_en = 3'b000;
        bus.int_taken = 1'b0;
        bus.mret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        zero_chk("rst");
        reset = 1'b0;
        tick();

        // Single external request, then all three sources together
        run_case(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
        run_case(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
        // Timer request withdrawn by gie
        run_case(1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1);

        // Masked external source, then unmasked
        bus.gie = 1'b1;
        bus.int_en = 3'b011;
        bus.external_int = 1'b1;
        quiet("ext_masked", 6);
        bus.int_en = 3'b111;
        wait_req("ext_unmask", 2, C_EXT);
        serve_chain(C_EXT);
        idle();

        // Source ignores the ack: drain timeout
        bus.external_int = 1'b1;
        wait_req("tmo_req", 2 + SYNC, C_EXT);
        serve(C_EXT, 1'b1);
        idle();
        check("ack_err_sticky", 32'(bus.ack_err), 32'd1);

        // Async reset while in REQ
        bus.timer_int = 1'b1;
        wait_req("rst_req", 2, C_TMR);
        #2 reset = 1'b1;
        #1 zero_chk("rst_in_req");
        m_ackerr = 1'b0;
        m_swpend = 1'b0;
        bus.timer_int = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Async reset while in DRAIN
        bus.external_int = 1'b1;
        wait_req("rst_drn_req", 2 + SYNC, C_EXT);
        bus.int_taken = 1'b1;
        tick();
        bus.int_taken = 1'b0;
        check("rst_drn_ack", 32'(bus.ext_int_ack), 32'd1);
        tick();
        #2 reset = 1'b1;
        #1 zero_chk("rst_in_drain");
        bus.external_int = 1'b0;
        quiet("rst_hold_quiet", 3);
        @(posedge clk);
        #1 reset = 1'b0;
        quiet("rst_after_quiet", 4);

        // Randomized source/enable/gie mixes
        for (int it = 0; it < 60; it++) begin
            logic e, s, t, g, w;
            logic [2:0] en;
            e  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            t  = 1'($urandom_range(0, 1));
            g  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 3) == 0);
            en = 3'($urandom);
            run_case(e, s, t, g, en, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
